// File: rtl/board_judge.sv
// board_judge -- sequential outcome evaluator for a 3x3 tic-tac-toe board.
//
// On an accepted start it snapshots the packed board. It then walks the eight
// winning lines, one per clock, and publishes winner / winning line / draw /
// error together with a one-cycle done pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   matrix     packed board, cell i at [2i+1:2i]; 00 empty, 01 P1, 10 P2, 11 illegal
//   start      request an evaluation; only honoured while idle
//   busy       scan in progress
//   done       one-cycle pulse, results valid from this cycle
//   winner     00 none, 01 player 1, 10 player 2
//   win_line   index of the first winning line, 0 when there is no winner
//   draw       no winner and no empty cell
//   error      illegal cell present, or both players own a complete line
//   game_over  sticky: set on any result with a winner or a draw
module board_judge (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] matrix,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [1:0]  winner,
    output logic [2:0]  win_line,
    output logic        draw,
    output logic        error,
    output logic        game_over
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state, state_n;
    logic [17:0] snap, snap_n;
    logic [2:0]  idx, idx_n;

    // Accumulators for the scan in progress.
    logic [1:0]  acc_win, acc_win_n;
    logic [2:0]  acc_line, acc_line_n;
    logic        acc_err, acc_err_n;

    logic        done_n;
    logic [1:0]  winner_n;
    logic [2:0]  win_line_n;
    logic        draw_n, error_n, game_over_n;

    // Accumulator values after folding in the line at idx.
    logic [1:0]  scan_win;
    logic [2:0]  scan_line;
    logic        scan_err;
    logic [1:0]  owner;
    logic [11:0] cells;
    logic        any_empty, any_illegal;

    function automatic logic [1:0] cell_of(input logic [17:0] m, input logic [3:0] i);
        logic [4:0] base;
        base = {i, 1'b0};
        return m[base +: 2];
    endfunction

    // Cell indices {a, b, c} of each winning line, 4 bits each.
    function automatic logic [11:0] line_cells(input logic [2:0] l);
        logic [11:0] r;
        case (l)
            3'd0:    r = {4'd0, 4'd1, 4'd2};
            3'd1:    r = {4'd3, 4'd4, 4'd5};
            3'd2:    r = {4'd6, 4'd7, 4'd8};
            3'd3:    r = {4'd0, 4'd3, 4'd6};
            3'd4:    r = {4'd1, 4'd4, 4'd7};
            3'd5:    r = {4'd2, 4'd5, 4'd8};
            3'd6:    r = {4'd0, 4'd4, 4'd8};
            default: r = {4'd2, 4'd4, 4'd6};
        endcase
        return r;
    endfunction

    // Owner of the current line. 11 cells never count as a win.
    always_comb begin
        logic [1:0] a, b, c;
        cells = line_cells(idx);
        a = cell_of(snap, cells[11:8]);
        b = cell_of(snap, cells[7:4]);
        c = cell_of(snap, cells[3:0]);
        owner = 2'b00;
        if (a == b && b == c && (a == 2'b01 || a == 2'b10))
            owner = a;
    end

    // Fold the current line into the accumulators. The first win is kept.
    // A later win by the other player flags an error. A later win by the
    // same player changes nothing.
    always_comb begin
        scan_win  = acc_win;
        scan_line = acc_line;
        scan_err  = acc_err;
        if (owner != 2'b00) begin
            if (acc_win == 2'b00) begin
                scan_win  = owner;
                scan_line = idx;
            end else if (owner != acc_win) begin
                scan_err = 1'b1;
            end
        end
    end

    // Whole-board occupancy facts, taken from the snapshot only.
    always_comb begin
        any_empty   = 1'b0;
        any_illegal = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (cell_of(snap, 4'(i)) == 2'b00) any_empty   = 1'b1;
            if (cell_of(snap, 4'(i)) == 2'b11) any_illegal = 1'b1;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_n     = state;
        snap_n      = snap;
        idx_n       = idx;
        acc_win_n   = acc_win;
        acc_line_n  = acc_line;
        acc_err_n   = acc_err;
        done_n      = 1'b0;
        winner_n    = winner;
        win_line_n  = win_line;
        draw_n      = draw;
        error_n     = error;
        game_over_n = game_over;

        case (state)
            IDLE: begin
                if (start) begin
                    snap_n     = matrix;
                    idx_n      = 3'd0;
                    acc_win_n  = 2'b00;
                    acc_line_n = 3'd0;
                    acc_err_n  = 1'b0;
                    state_n    = SCAN;
                end
            end
            SCAN: begin
                acc_win_n  = scan_win;
                acc_line_n = scan_line;
                acc_err_n  = scan_err;
                idx_n      = idx + 3'd1;
                if (idx == 3'd7) begin
                    // The last line is published on the same edge it is folded in.
                    state_n     = IDLE;
                    idx_n       = 3'd0;
                    done_n      = 1'b1;
                    winner_n    = scan_win;
                    win_line_n  = scan_line;
                    draw_n      = (scan_win == 2'b00) && !any_empty;
                    error_n     = any_illegal || scan_err;
                    game_over_n = game_over || (scan_win != 2'b00) ||
                                  ((scan_win == 2'b00) && !any_empty);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snap      <= '0;
            idx       <= '0;
            acc_win   <= '0;
            acc_line  <= '0;
            acc_err   <= 1'b0;
            done      <= 1'b0;
            winner    <= '0;
            win_line  <= '0;
            draw      <= 1'b0;
            error     <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            snap      <= snap_n;
            idx       <= idx_n;
            acc_win   <= acc_win_n;
            acc_line  <= acc_line_n;
            acc_err   <= acc_err_n;
            done      <= done_n;
            winner    <= winner_n;
            win_line  <= win_line_n;
            draw      <= draw_n;
            error     <= error_n;
            game_over <= game_over_n;
        end
    end

    assign busy = (state == SCAN);

endmodule
